// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encodings and default timing constants for the button path
// Contents:
//   btn_state_e        : 3-bit gesture FSM state encoding
//   DEFAULT_COUNT_SIZE : default gesture timer width
//   DEFAULT_LONG_LIMIT : 1 s hold at 12 MHz
//   DEFAULT_GAP_LIMIT  : 300 ms release gap at 12 MHz
package button_pkg;

    localparam int unsigned DEFAULT_COUNT_SIZE = 24;
    localparam logic [23:0] DEFAULT_LONG_LIMIT = 24'd11_999_999;
    localparam logic [23:0] DEFAULT_GAP_LIMIT  = 24'd3_599_999;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } btn_state_e;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchroniser with synchronous reset
// Ports:
//   clock : destination clock
//   reset : synchronous, active-high; clears both stages
//   d     : asynchronous input bus
//   q     : synchronised output (second stage)
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_events.sv
// rtl/button_events.sv - classifies a debounced button level into click / double_click / long_press pulses
// Ports:
//   clock        : system clock
//   reset        : synchronous, active-high; drops any gesture in progress
//   in           : debounced button level, asynchronous to clock
//   held         : synchronised button level
//   click        : one-cycle pulse, single press completed
//   double_click : one-cycle pulse, two presses within the gap limit
//   long_press   : one-cycle pulse, press held to the long limit
module button_events
    import button_pkg::*;
#(
    parameter int unsigned            COUNT_SIZE = DEFAULT_COUNT_SIZE,
    parameter logic [COUNT_SIZE-1:0]  LONG_LIMIT = COUNT_SIZE'(DEFAULT_LONG_LIMIT),
    parameter logic [COUNT_SIZE-1:0]  GAP_LIMIT  = COUNT_SIZE'(DEFAULT_GAP_LIMIT)
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic held,
    output logic click,
    output logic double_click,
    output logic long_press
);

    logic s2;
    logic s3_q, s3_d;
    logic rise, fall;

    btn_state_e            state_q, state_d;
    logic [COUNT_SIZE-1:0] timer_q, timer_d;
    logic                  click_q, click_d;
    logic                  double_q, double_d;
    logic                  long_q, long_d;

    sync2 #(.WIDTH(1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (in),
        .q     (s2)
    );

    assign s3_d = s2;
    assign rise = s2 & ~s3_q;
    assign fall = ~s2 & s3_q;

    always_comb begin
        state_d  = state_q;
        click_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;

        // Edges are tested before the timer limit so a real edge wins a tie.
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_GAP;
                end else if (timer_q == LONG_LIMIT) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                end else if (timer_q == GAP_LIMIT) begin
                    state_d = ST_IDLE;
                    click_d = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_d  = ST_IDLE;
                    double_d = 1'b1;
                end else if (timer_q == LONG_LIMIT) begin
                    // The first press already completed, so report it alongside the hold.
                    state_d = ST_LONG;
                    click_d = 1'b1;
                    long_d  = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timer restarts on every state entry and only runs in the timed states.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q inside {ST_PRESS1, ST_GAP, ST_PRESS2}) begin
            timer_d = timer_q + COUNT_SIZE'(1);
        end else begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            s3_q     <= 1'b0;
            click_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            s3_q     <= s3_d;
            click_q  <= click_d;
            double_q <= double_d;
            long_q   <= long_d;
        end
    end

    assign held         = s2;
    assign click        = click_q;
    assign double_click = double_q;
    assign long_press   = long_q;

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - self-checking bench for button_events
module tb_button_events;

    localparam int LL   = 20;
    localparam int GL   = 10;
    localparam int MAXN = 320;
    localparam int INF  = 1 << 30;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in    = 1'b0;
    logic held, click, double_click, long_press;

    int checks = 0;
    int errors = 0;

    button_events #(
        .COUNT_SIZE (8),
        .LONG_LIMIT (8'd20),
        .GAP_LIMIT  (8'd10)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in           (in),
        .held         (held),
        .click        (click),
        .double_click (double_click),
        .long_press   (long_press)
    );

    always #5 clock = ~clock;

    // wave[k] is the level sampled at edge k; act/exp_o[k] is {held, click, double, long} after edge k.
    logic       wave  [MAXN];
    logic [3:0] act   [MAXN];
    logic [3:0] exp_o [MAXN];

    typedef struct {
        string name;
        int h1, l1, h2;
        int n_click, t_click;
        int n_dbl, t_dbl;
        int n_long, t_long;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic signed [31:0] actual, input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in    = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_wave(input int n);
        for (int k = 0; k < n; k++) begin
            in = wave[k];
            @(posedge clock);
            #1;
            act[k] = {held, click, double_click, long_press};
        end
    endtask

    task automatic mark(input int n, input int t, input logic [2:0] bits);
        if (t < n) exp_o[t][2:0] = exp_o[t][2:0] | bits;
    endtask

    // Reference: works on press/release durations measured at the FSM (two edges after sampling).
    task automatic model(input int n);
        int   rises[$];
        int   falls[$];
        int   i, r1, f1, r2, f2;
        logic prev;
        prev = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_o[k] = {(k > 0) ? wave[k-1] : 1'b0, 3'b000};
            if (wave[k] && !prev) rises.push_back(k + 2);
            if (!wave[k] && prev) falls.push_back(k + 2);
            prev = wave[k];
        end
        i = 0;
        while (i < rises.size()) begin
            r1 = rises[i];
            f1 = (i < falls.size()) ? falls[i] : INF;
            if (f1 - r1 >= LL + 2) begin
                mark(n, r1 + LL + 1, 3'b001);
                i = i + 1;
            end else begin
                r2 = (i + 1 < rises.size()) ? rises[i+1] : INF;
                if (r2 - f1 >= GL + 2) begin
                    mark(n, f1 + GL + 1, 3'b100);
                    i = i + 1;
                end else begin
                    f2 = (i + 1 < falls.size()) ? falls[i+1] : INF;
                    if (f2 - r2 >= LL + 2) mark(n, r2 + LL + 1, 3'b101);
                    else                   mark(n, f2, 3'b010);
                    i = i + 2;
                end
            end
        end
    endtask

    task automatic pulse_stats(input int n, input int b, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int k = 0; k < n; k++) begin
            if (act[k][b] === 1'b1) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
    endtask

    initial begin
        int cnt, first, len, k;
        logic lvl;

        vecs[0] = '{"single",     5,  0,  0, 1, 20, 0, -1, 0, -1};
        vecs[1] = '{"double",     5,  4,  5, 0, -1, 1, 18, 0, -1};
        vecs[2] = '{"long",      40,  0,  0, 0, -1, 0, -1, 1, 25};
        vecs[3] = '{"press_hold", 5,  4, 30, 1, 34, 0, -1, 1, 34};
        vecs[4] = '{"tie_gap",    5, 11,  5, 0, -1, 1, 25, 0, -1};
        vecs[5] = '{"gap_over",   5, 12,  5, 2, 20, 0, -1, 0, -1};
        vecs[6] = '{"tie_long",  21,  0,  0, 1, 36, 0, -1, 0, -1};
        vecs[7] = '{"long_over", 22,  0,  0, 0, -1, 0, -1, 1, 25};
        vecs[8] = '{"short_1cyc", 1,  1,  1, 0, -1, 1,  7, 0, -1};

        // Reset state
        reset = 1'b1;
        in    = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_outputs", {28'd0, held, click, double_click, long_press}, 0);

        // Directed table
        foreach (vecs[v]) begin
            do_reset();
            for (int j = 0; j < 80; j++) begin
                wave[j] = ((j >= 2) && (j < 2 + vecs[v].h1)) ||
                          ((vecs[v].h2 > 0) && (j >= 2 + vecs[v].h1 + vecs[v].l1) &&
                           (j < 2 + vecs[v].h1 + vecs[v].l1 + vecs[v].h2));
            end
            run_wave(80);
            pulse_stats(80, 2, cnt, first);
            check($sformatf("%s click_count", vecs[v].name), cnt, vecs[v].n_click);
            check($sformatf("%s click_time", vecs[v].name), first, vecs[v].t_click);
            pulse_stats(80, 1, cnt, first);
            check($sformatf("%s double_count", vecs[v].name), cnt, vecs[v].n_dbl);
            check($sformatf("%s double_time", vecs[v].name), first, vecs[v].t_dbl);
            pulse_stats(80, 0, cnt, first);
            check($sformatf("%s long_count", vecs[v].name), cnt, vecs[v].n_long);
            check($sformatf("%s long_time", vecs[v].name), first, vecs[v].t_long);
        end

        // Reset mid-GAP with the button pressed again across reset
        do_reset();
        for (int j = 0; j < 12; j++) wave[j] = (j >= 2) && (j <= 6);
        run_wave(12);
        cnt = 0;
        for (int j = 0; j < 12; j++) cnt += (act[j][2:0] != 3'b000) ? 1 : 0;
        check("pre_reset_pulses", cnt, 0);
        reset = 1'b1;
        in    = 1'b1;
        @(posedge clock);
        #1;
        check("mid_reset_outputs", {28'd0, held, click, double_click, long_press}, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 40; j++) wave[j] = 1'b1;
        run_wave(40);
        check("post_reset_held0", act[0][3], 0);
        check("post_reset_held1", act[1][3], 1);
        pulse_stats(40, 2, cnt, first);
        check("post_reset_click_count", cnt, 0);
        pulse_stats(40, 1, cnt, first);
        check("post_reset_double_count", cnt, 0);
        pulse_stats(40, 0, cnt, first);
        check("post_reset_long_time", first, 23);
        check("post_reset_long_count", cnt, 1);

        // Randomised run lengths clustered around the gap and long boundaries
        for (int trial = 0; trial < 10; trial++) begin
            k   = 0;
            lvl = 1'b0;
            len = int'($urandom_range(0, 3));
            while (k < 300) begin
                for (int j = 0; j < len && k < 300; j++) begin
                    wave[k] = lvl;
                    k++;
                end
                lvl = ~lvl;
                case ($urandom_range(0, 4))
                    0:       len = int'($urandom_range(1, 4));
                    1:       len = int'($urandom_range(9, 13));
                    2:       len = int'($urandom_range(19, 23));
                    3:       len = int'($urandom_range(5, 8));
                    default: len = int'($urandom_range(24, 40));
                endcase
            end
            do_reset();
            run_wave(300);
            model(300);
            for (int j = 0; j < 300; j++) begin
                check($sformatf("rand%0d cycle%0d {held,click,dbl,long}", trial, j),
                      {28'd0, act[j]}, {28'd0, exp_o[j]});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
